// File: rtl/pass_pkg.sv
// Shared constants and helpers for the pass_pipe pipeline and its bench.
package pass_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pass_stage.sv
// One pipeline stage: a valid bit plus a payload register that only loads real words.
module pass_stage
    import pass_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_d,
    output logic             out_v,
    output logic [WIDTH-1:0] out_d
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Bubbles update the valid bit only, so the payload stays quiet when idle.
    always_comb begin
        v_d = load ? in_v : v_q;
        d_d = (load && in_v) ? in_d : d_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; the data register is reset too,
    // so out_data reads 0 rather than X straight after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign out_v = v_q;
    assign out_d = d_q;

endmodule

// File: rtl/pass_pipe.sv
// DEPTH-stage valid/ready pipeline with bubble collapse and an occupancy counter.
// Optional synchronous flush port when PASS_PIPE_FLUSH_EN is defined.
module pass_pipe
    import pass_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [occ_w(DEPTH)-1:0]   occupancy
`ifdef PASS_PIPE_FLUSH_EN
    ,
    input  logic                      flush
`endif
);

    localparam int OCC_W = occ_w(DEPTH);

    if (DEPTH < 1) begin : g_depth_chk
        $error("pass_pipe: DEPTH must be at least 1");
    end

    logic             flush_act;
    logic [DEPTH-1:0] v, rdy, ld, src_v;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             in_fire, out_fire;
    logic [OCC_W-1:0] occ_q, occ_d;

`ifdef PASS_PIPE_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // An empty stage always accepts, which is what collapses bubbles under stall.
    always_comb begin
        rdy            = '0;
        rdy[DEPTH-1]   = !v[DEPTH-1] || out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = !v[i] || rdy[i+1];
        end
    end

    // Flush forces every stage to load a bubble; payloads are left untouched.
    // NOTE: every signal written here gets a value first, so no latch is inferred.
    always_comb begin
        src_v    = '0;
        ld       = '0;
        src_v[0] = in_valid && !flush_act;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v[i-1] && !flush_act;
            src_d[i] = d[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            ld[i] = rdy[i] || flush_act;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pass_stage #(.WIDTH(WIDTH)) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (ld[i]),
            .in_v    (src_v[i]),
            .in_d    (src_d[i]),
            .out_v   (v[i]),
            .out_d   (d[i])
        );
    end

    assign in_ready  = rdy[0] && !flush_act;
    assign out_valid = v[DEPTH-1] && !flush_act;
    assign out_data  = d[DEPTH-1];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush_act) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pass_pipe.sv
// Scoreboard bench for pass_pipe (WIDTH=8, DEPTH=3); flush scenario runs when
// PASS_PIPE_FLUSH_EN is defined.
module tb_pass_pipe;
    import pass_pkg::*;

    localparam int W = DEF_WIDTH;
    localparam int D = DEF_DEPTH;

    logic                  clock;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          out_data;
    logic [occ_w(D)-1:0]   occupancy;
    logic                  flush;

    int n_checks = 0;
    int n_err    = 0;
    int n_out    = 0;
    logic [W-1:0] exp_q [$];

    pass_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PASS_PIPE_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int cycles);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (cycles) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: invariant checks, then pops/pushes for the fires at the coming edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            check("occ_model", occupancy, exp_q.size());
            check("occ_popcount", occupancy, $countones(dut.v));
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL sb_unexpected: got %0h with no word expected", out_data);
                    end else begin
                        check("sb_data", out_data, exp_q.pop_front());
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(in_data);
            end
        end
    end

    int base;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_out_data", out_data, 0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Latency: single word, visible after edge 2, exactly once.
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        #1;
        check("lat_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("lat_e0_valid", out_valid, 0);
        tick();
        check("lat_e1_valid", out_valid, 0);
        tick();
        check("lat_e2_valid", out_valid, 1);
        check("lat_e2_data", out_data, 8'hA5);
        tick();
        check("lat_e3_valid", out_valid, 0);
        check("lat_hold_data", out_data, 8'hA5);
        drain(2);

        // Streaming 0x01..0x10 back to back.
        base = n_out;
        for (int n = 1; n <= 16; n++) begin
            in_valid = 1'b1;
            in_data  = W'(n);
            #1;
            check("str_in_ready", in_ready, 1);
            tick();
            if (n >= 3) begin
                check("str_occ", occupancy, 3);
                check("str_out_valid", out_valid, 1);
                check("str_out_data", out_data, n - 2);
            end
        end
        drain(5);
        check("str_count", n_out - base, 16);

        // Stall fill, then release.
        base      = n_out;
        out_ready = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            in_valid = 1'b1;
            in_data  = W'(n * 8'h11);
            #1;
            check("fill_in_ready", in_ready, 1);
            tick();
        end
        in_data = 8'h44;
        #1;
        check("fill_full_ready", in_ready, 0);
        check("fill_full_occ", occupancy, 3);
        check("fill_full_out", out_data, 8'h11);
        out_ready = 1'b1;
        #1;
        check("full_pass_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("full_pass_occ", occupancy, 3);
        drain(5);
        check("fill_count", n_out - base, 4);

        // Bubble collapse: only stage 2 holds 0x5A.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("bub_occ1", occupancy, 1);
        check("bub_out_data", out_data, 8'h5A);
        in_valid = 1'b1;
        in_data  = 8'h6B;
        #1;
        check("bub_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bub_occ2", occupancy, 2);
        check("bub_hold_valid", out_valid, 1);
        check("bub_hold_data", out_data, 8'h5A);
        drain(5);

        // Reset mid-stream with two words in flight.
        base      = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hC1;
        tick();
        in_data = 8'hC2;
        tick();
        in_valid = 1'b0;
        check("mid_occ", occupancy, 2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_data", out_data, 0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("mid_rel_ready", in_ready, 1);
        check("mid_rel_valid", out_valid, 0);
        check("mid_rel_occ", occupancy, 0);
        drain(5);
        check("mid_no_ghost", n_out - base, 0);

`ifdef PASS_PIPE_FLUSH_EN
        // Flush a full pipe for one cycle, then send 0x77.
        out_ready = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            in_valid = 1'b1;
            in_data  = W'(8'h80 + n);
            tick();
        end
        in_valid = 1'b0;
        check("fl_occ_full", occupancy, 3);
        flush = 1'b1;
        #1;
        check("fl_in_ready", in_ready, 0);
        check("fl_out_valid", out_valid, 0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_occ", occupancy, 0);
        check("fl_after_valid", out_valid, 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        #1;
        check("fl_new_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("fl_new_e0", out_valid, 0);
        tick();
        check("fl_new_e1", out_valid, 0);
        tick();
        check("fl_new_e2_valid", out_valid, 1);
        check("fl_new_e2_data", out_data, 8'h77);
        drain(3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
